// File: rtl/usi_uart_pkg.sv
// Shared encodings, state enums and helpers for the USI UART transceiver.
// Imported by the tick counter and the transceiver top.
package usi_uart_pkg;

  localparam int TCW = 6;

  localparam logic [1:0] PAR_ODD   = 2'b00;
  localparam logic [1:0] PAR_EVEN  = 2'b01;
  localparam logic [1:0] PAR_MARK  = 2'b10;
  localparam logic [1:0] PAR_SPACE = 2'b11;

  localparam logic [1:0] STOP_1   = 2'b00;
  localparam logic [1:0] STOP_1P5 = 2'b01;
  localparam logic [1:0] STOP_2   = 2'b10;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_PAR,
    TX_STOP
  } tx_state_t;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_PAR,
    RX_STOP,
    RX_WAIT_HI
  } rx_state_t;

  function automatic logic [3:0] dbit_cnt(input logic [1:0] d);
    return 4'd5 + {2'b00, d};
  endfunction

  function automatic logic [7:0] dbit_mask(input logic [1:0] d);
    return 8'hFF >> (2'd3 - d);
  endfunction

  // Line value of the parity bit for already-masked data.
  function automatic logic par_bit(input logic [7:0] d,
                                   input logic [1:0] pt);
    logic p;
    p = 1'b0;
    unique case (pt)
      PAR_ODD:  p = ~^d;
      PAR_EVEN: p = ^d;
      PAR_MARK: p = 1'b1;
      default:  p = 1'b0;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/usi_uart_tick.sv
// Baud tick generator: one tick every div+1 clocks.
// Synchronous restart aligns the tick phase to a frame start.
module usi_uart_tick
  import usi_uart_pkg::*;
#(
  parameter int DIV_W = 24
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             restart,
  input  logic [DIV_W-1:0] div,
  output logic             tick
);

  localparam logic [DIV_W-1:0] ONE = DIV_W'(1);

  logic [DIV_W-1:0] cnt;

  assign tick = en & (cnt == div);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (!en || restart || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + ONE;
    end
  end

endmodule

// File: rtl/usi_uart_xcvr.sv
// Full-duplex UART transceiver: parametrised divider and oversampling,
// valid/ready TX, majority-vote RX with parity, framing and break flags.
module usi_uart_xcvr
  import usi_uart_pkg::*;
#(
  parameter int DIV_W = 24,
  parameter int OSR   = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_en,
  input  logic [DIV_W-1:0] cfg_div,
  input  logic [1:0]       cfg_dbit,
  input  logic             cfg_pen,
  input  logic [1:0]       cfg_ptype,
  input  logic [1:0]       cfg_stop,
  input  logic             tx_valid,
  input  logic [7:0]       tx_data,
  output logic             tx_ready,
  output logic             txd,
  output logic             tx_busy,
  input  logic             rxd,
  output logic             rx_valid,
  output logic [7:0]       rx_data,
  output logic             rx_perr,
  output logic             rx_ferr,
  output logic             rx_break,
  output logic             rx_busy
);

  localparam logic [TCW-1:0] TC_ONE  = TCW'(1);
  localparam logic [TCW-1:0] T_LAST  = TCW'(OSR - 1);
  localparam logic [TCW-1:0] T_S15   = TCW'(3 * OSR / 2 - 1);
  localparam logic [TCW-1:0] T_S2    = TCW'(2 * OSR - 1);
  localparam logic [TCW-1:0] T_MID0  = TCW'(OSR / 2 - 2);
  localparam logic [TCW-1:0] T_MID1  = TCW'(OSR / 2 - 1);
  localparam logic [TCW-1:0] T_MID2  = TCW'(OSR / 2);

  // ---------------- TX ----------------
  tx_state_t        tx_st;
  logic             rdy_ok;
  logic [DIV_W-1:0] tx_div;
  logic [1:0]       tx_dbit;
  logic             tx_pen;
  logic [1:0]       tx_stop;
  logic [7:0]       tx_shr;
  logic             tx_par;
  logic [2:0]       tx_bit;
  logic [TCW-1:0]   tx_tc;
  logic [TCW-1:0]   tx_len;
  logic             tx_tick;
  logic             tx_last;
  logic             tx_go;
  logic             tx_dlast;
  logic [7:0]       tx_md;

  always_comb begin
    tx_len = T_LAST;
    if (tx_st == TX_STOP) begin
      unique case (tx_stop)
        STOP_1:   tx_len = T_LAST;
        STOP_1P5: tx_len = T_S15;
        default:  tx_len = T_S2;
      endcase
    end
  end

  assign tx_last  = tx_tick & (tx_tc == tx_len);
  assign tx_ready = rdy_ok & cfg_en &
                    ((tx_st == TX_IDLE) | ((tx_st == TX_STOP) & tx_last));
  assign tx_go    = tx_valid & tx_ready;
  assign tx_busy  = (tx_st != TX_IDLE);
  assign tx_dlast = ({1'b0, tx_bit} == dbit_cnt(tx_dbit) - 4'd1);
  assign tx_md    = tx_data & dbit_mask(cfg_dbit);

  usi_uart_tick #(.DIV_W(DIV_W)) u_tx_tick (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (cfg_en),
    .restart (tx_go),
    .div     (tx_div),
    .tick    (tx_tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdy_ok  <= 1'b0;
      tx_st   <= TX_IDLE;
      txd     <= 1'b1;
      tx_div  <= '0;
      tx_dbit <= '0;
      tx_pen  <= 1'b0;
      tx_stop <= '0;
      tx_shr  <= '0;
      tx_par  <= 1'b0;
      tx_bit  <= '0;
      tx_tc   <= '0;
    end else begin
      rdy_ok <= 1'b1;
      if (!cfg_en) begin
        tx_st <= TX_IDLE;
        txd   <= 1'b1;
        tx_tc <= '0;
      end else if (tx_go) begin
        tx_st   <= TX_START;
        txd     <= 1'b0;
        tx_div  <= cfg_div;
        tx_dbit <= cfg_dbit;
        tx_pen  <= cfg_pen;
        tx_stop <= cfg_stop;
        tx_shr  <= tx_md;
        tx_par  <= par_bit(tx_md, cfg_ptype);
        tx_bit  <= '0;
        tx_tc   <= '0;
      end else if (tx_tick && tx_st != TX_IDLE) begin
        if (!tx_last) begin
          tx_tc <= tx_tc + TC_ONE;
        end else begin
          tx_tc <= '0;
          unique case (tx_st)
            TX_START: begin
              tx_st  <= TX_DATA;
              txd    <= tx_shr[0];
              tx_shr <= tx_shr >> 1;
              tx_bit <= '0;
            end
            TX_DATA: begin
              if (tx_dlast) begin
                tx_st <= tx_pen ? TX_PAR : TX_STOP;
                txd   <= tx_pen ? tx_par : 1'b1;
              end else begin
                tx_bit <= tx_bit + 3'd1;
                txd    <= tx_shr[0];
                tx_shr <= tx_shr >> 1;
              end
            end
            TX_PAR: begin
              tx_st <= TX_STOP;
              txd   <= 1'b1;
            end
            default: begin
              tx_st <= TX_IDLE;
              txd   <= 1'b1;
            end
          endcase
        end
      end
    end
  end

  // ---------------- RX ----------------
  rx_state_t        rx_st;
  logic             rx_s1;
  logic             rx_s2;
  logic             rx_s3;
  logic [DIV_W-1:0] rx_div;
  logic [1:0]       rx_dbit;
  logic             rx_pen;
  logic [1:0]       rx_ptype;
  logic [7:0]       rx_buf;
  logic             rx_par;
  logic [2:0]       rx_bit;
  logic [TCW-1:0]   rx_tc;
  logic             rx_v0;
  logic             rx_v1;
  logic             rx_tick;
  logic             rx_start;
  logic             rx_mid;
  logic             maj;
  logic             rx_dlast;

  assign rx_start = cfg_en & (rx_st == RX_IDLE) & rx_s3 & ~rx_s2;
  assign rx_mid   = rx_tick & (rx_tc == T_MID2);
  assign maj      = (rx_v0 & rx_v1) | (rx_v0 & rx_s2) | (rx_v1 & rx_s2);
  assign rx_dlast = ({1'b0, rx_bit} == dbit_cnt(rx_dbit) - 4'd1);
  assign rx_busy  = (rx_st != RX_IDLE) & (rx_st != RX_WAIT_HI);

  usi_uart_tick #(.DIV_W(DIV_W)) u_rx_tick (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (cfg_en),
    .restart (rx_start),
    .div     (rx_div),
    .tick    (rx_tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_s1    <= 1'b1;
      rx_s2    <= 1'b1;
      rx_s3    <= 1'b1;
      rx_st    <= RX_IDLE;
      rx_div   <= '0;
      rx_dbit  <= '0;
      rx_pen   <= 1'b0;
      rx_ptype <= '0;
      rx_buf   <= '0;
      rx_par   <= 1'b0;
      rx_bit   <= '0;
      rx_tc    <= '0;
      rx_v0    <= 1'b1;
      rx_v1    <= 1'b1;
      rx_valid <= 1'b0;
      rx_data  <= '0;
      rx_perr  <= 1'b0;
      rx_ferr  <= 1'b0;
      rx_break <= 1'b0;
    end else begin
      rx_s1    <= rxd;
      rx_s2    <= rx_s1;
      rx_s3    <= rx_s2;
      rx_valid <= 1'b0;
      if (!cfg_en) begin
        rx_st <= RX_IDLE;
        rx_tc <= '0;
      end else if (rx_start) begin
        rx_st    <= RX_START;
        rx_tc    <= '0;
        rx_div   <= cfg_div;
        rx_dbit  <= cfg_dbit;
        rx_pen   <= cfg_pen;
        rx_ptype <= cfg_ptype;
        rx_buf   <= '0;
        rx_bit   <= '0;
      end else if (rx_st == RX_WAIT_HI) begin
        // Hold off re-arming until the line idles high again.
        if (rx_s2) rx_st <= RX_IDLE;
      end else if (rx_tick && rx_st != RX_IDLE) begin
        rx_tc <= (rx_tc == T_LAST) ? '0 : rx_tc + TC_ONE;
        if (rx_tc == T_MID0) rx_v0 <= rx_s2;
        if (rx_tc == T_MID1) rx_v1 <= rx_s2;
        if (rx_mid) begin
          unique case (rx_st)
            RX_START: begin
              rx_st <= maj ? RX_IDLE : RX_DATA;
            end
            RX_DATA: begin
              rx_buf[rx_bit] <= maj;
              if (rx_dlast) begin
                rx_st <= rx_pen ? RX_PAR : RX_STOP;
              end else begin
                rx_bit <= rx_bit + 3'd1;
              end
            end
            RX_PAR: begin
              rx_par <= maj;
              rx_st  <= RX_STOP;
            end
            default: begin
              rx_valid <= 1'b1;
              rx_data  <= rx_buf;
              rx_perr  <= rx_pen &
                          (rx_par != par_bit(rx_buf, rx_ptype));
              rx_ferr  <= ~maj;
              rx_break <= ~maj & (rx_buf == 8'h00) &
                          (~rx_pen | ~rx_par);
              rx_st    <= RX_WAIT_HI;
            end
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_usi_uart_xcvr.sv
// Self-checking bench for usi_uart_xcvr: directed and random frames
// against a per-clock line model built from the frame format rules.
module tb_usi_uart_xcvr;

  localparam int DIV_W = 24;
  localparam int OSR   = 16;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             cfg_en = 1'b1;
  logic [DIV_W-1:0] cfg_div = '0;
  logic [1:0]       cfg_dbit = 2'b11;
  logic             cfg_pen = 1'b0;
  logic [1:0]       cfg_ptype = 2'b00;
  logic [1:0]       cfg_stop = 2'b00;
  logic             tx_valid = 1'b0;
  logic [7:0]       tx_data = '0;
  logic             tx_ready;
  logic             txd;
  logic             tx_busy;
  logic             rxd;
  logic             rx_valid;
  logic [7:0]       rx_data;
  logic             rx_perr;
  logic             rx_ferr;
  logic             rx_break;
  logic             rx_busy;

  logic loop = 1'b0;
  logic rxd_drv = 1'b1;
  assign rxd = loop ? txd : rxd_drv;

  always #5 clk = ~clk;

  usi_uart_xcvr #(.DIV_W(DIV_W), .OSR(OSR)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cfg_en    (cfg_en),
    .cfg_div   (cfg_div),
    .cfg_dbit  (cfg_dbit),
    .cfg_pen   (cfg_pen),
    .cfg_ptype (cfg_ptype),
    .cfg_stop  (cfg_stop),
    .tx_valid  (tx_valid),
    .tx_data   (tx_data),
    .tx_ready  (tx_ready),
    .txd       (txd),
    .tx_busy   (tx_busy),
    .rxd       (rxd),
    .rx_valid  (rx_valid),
    .rx_data   (rx_data),
    .rx_perr   (rx_perr),
    .rx_ferr   (rx_ferr),
    .rx_break  (rx_break),
    .rx_busy   (rx_busy)
  );

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [7:0] d;
    logic       p;
    logic       f;
    logic       b;
  } rxr_t;
  rxr_t rx_q[$];

  always @(posedge clk) begin
    if (rx_valid === 1'b1)
      rx_q.push_back('{rx_data, rx_perr, rx_ferr, rx_break});
  end

  // Model state: current frame format and expected line waveform.
  int   g_nd, g_pen, g_pt, g_stop, g_div;
  logic wave[$];

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_cfg(input int nd, input int pen, input int pt,
                         input int stp, input int div);
    g_nd = nd; g_pen = pen; g_pt = pt; g_stop = stp; g_div = div;
    cfg_dbit  = 2'(nd - 5);
    cfg_pen   = 1'(pen);
    cfg_ptype = 2'(pt);
    cfg_stop  = 2'(stp);
    cfg_div   = DIV_W'(div);
  endtask

  function automatic logic [7:0] mask_d(input logic [7:0] d);
    logic [8:0] m;
    m = (9'd1 << g_nd) - 9'd1;
    return d & m[7:0];
  endfunction

  function automatic logic good_par(input logic [7:0] d);
    int ones;
    ones = $countones(mask_d(d));
    case (g_pt)
      0: return (ones % 2 == 0);
      1: return (ones % 2 == 1);
      2: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  task automatic seg(input logic lvl, input int ticks);
    repeat (ticks * (g_div + 1)) wave.push_back(lvl);
  endtask

  task automatic build(input logic [7:0] d, input bit flip, input bit s0);
    int st;
    wave.delete();
    seg(1'b0, OSR);
    for (int i = 0; i < g_nd; i++) seg(d[i], OSR);
    if (g_pen != 0) seg(good_par(d) ^ flip, OSR);
    st = (g_stop == 0) ? OSR : (g_stop == 1) ? 3 * OSR / 2 : 2 * OSR;
    seg(~s0, st);
  endtask

  task automatic accept();
    bit ok;
    ok = 0;
    for (int n = 0; n < 5000; n++) begin
      if (tx_ready === 1'b1) begin
        ok = 1;
        @(posedge clk); #1;
        break;
      end
      @(posedge clk); #1;
    end
    chk("tx_accept", 32'(ok), 1);
  endtask

  task automatic tx_run(input logic [7:0] d, input int nfr,
                        output int mism, output int busy,
                        output int tail, output int rerr);
    int L;
    L = wave.size();
    mism = 0; busy = 0; tail = 0; rerr = 0;
    tx_data  = d;
    tx_valid = 1'b1;
    accept();
    for (int k = 0; k < nfr * L; k++) begin
      if (txd !== wave[k % L]) mism++;
      if (tx_busy === 1'b1) busy++;
      if (txd === 1'b1) tail++; else tail = 0;
      if (k % L == L - 1 && tx_ready !== 1'b1) rerr++;
      if (k % L == L - 2 && tx_ready !== 1'b0) rerr++;
      if (k == nfr * L - 1) tx_valid = 1'b0;
      @(posedge clk); #1;
    end
    tx_valid = 1'b0;
  endtask

  task automatic rx_drive(input int idle);
    for (int k = 0; k < wave.size(); k++) begin
      rxd_drv = wave[k];
      @(posedge clk); #1;
    end
    rxd_drv = 1'b1;
    repeat (idle) begin @(posedge clk); #1; end
  endtask

  task automatic chk_rx(input string tag, input logic [7:0] d,
                        input logic p, input logic f, input logic b);
    chk({tag, "_cnt"}, 32'(rx_q.size()), 1);
    if (rx_q.size() > 0) begin
      chk({tag, "_data"}, {24'd0, rx_q[0].d}, {24'd0, d});
      chk({tag, "_flags"}, {29'd0, rx_q[0].p, rx_q[0].f, rx_q[0].b},
          {29'd0, p, f, b});
    end
  endtask

  initial begin
    int mism, busy, tail, rerr;
    logic [7:0] d;
    bit saw, dropped;
    int lb_bytes[3] = '{8'h00, 8'h7F, 8'h55};

    set_cfg(8, 0, 0, 0, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_txd", 32'(txd), 1);
    chk("rst_tx_ready", 32'(tx_ready), 0);
    chk("rst_busy", {30'd0, tx_busy, rx_busy}, 0);
    chk("rst_rx", {21'd0, rx_valid, rx_data, rx_perr, rx_ferr, rx_break}, 0);
    rst_n = 1'b1;
    chk("rel_tx_ready_lo", 32'(tx_ready), 0);
    @(posedge clk); #1;
    chk("rel_tx_ready_hi", 32'(tx_ready), 1);

    // 8N1 0xA5 at full clock rate
    build(8'hA5, 0, 0);
    tx_run(8'hA5, 1, mism, busy, tail, rerr);
    chk("a5_wave", 32'(mism), 0);
    chk("a5_len", 32'(busy), 10 * OSR);
    chk("a5_ready", 32'(rerr), 0);
    chk("a5_idle", {30'd0, tx_busy, txd}, 1);

    // 5N1.5 0x1F, three frames back to back
    set_cfg(5, 0, 0, 1, 0);
    build(8'h1F, 0, 0);
    tx_run(8'h1F, 3, mism, busy, tail, rerr);
    chk("b2b_wave", 32'(mism), 0);
    chk("b2b_len", 32'(busy), 3 * ((1 + 5) * OSR + 24));
    chk("b2b_ready", 32'(rerr), 0);

    // Loopback 7E2, div=3
    loop = 1'b1;
    set_cfg(7, 1, 1, 2, 3);
    foreach (lb_bytes[i]) begin
      d = 8'(lb_bytes[i]);
      rx_q.delete();
      build(d, 0, 0);
      tx_run(d, 1, mism, busy, tail, rerr);
      chk("lb_wave", 32'(mism), 0);
      chk_rx("lb", d & 8'h7F, 0, 0, 0);
      if (i == 0) chk("lb_stop_len", 32'(tail), 2 * OSR * 4);
    end

    // Random formats in loopback
    for (int i = 0; i < 8; i++) begin
      set_cfg(5 + $urandom_range(0, 3), $urandom_range(0, 1),
              $urandom_range(0, 3), $urandom_range(0, 2),
              $urandom_range(0, 2));
      d = 8'($urandom_range(0, 255));
      rx_q.delete();
      build(d, 0, 0);
      tx_run(d, 1, mism, busy, tail, rerr);
      chk("rnd_wave", 32'(mism), 0);
      chk_rx("rnd", mask_d(d), 0, 0, 0);
    end

    // Bench-driven RX: parity error, framing error, break
    loop = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    set_cfg(8, 1, 0, 0, 0);
    d = 8'($urandom_range(0, 255));
    rx_q.delete();
    build(d, 1, 0);
    rx_drive(40);
    chk_rx("perr", d, 1, 0, 0);

    set_cfg(8, 0, 0, 0, 0);
    rx_q.delete();
    build(8'h5A, 0, 1);
    rx_drive(40);
    chk_rx("ferr", 8'h5A, 0, 1, 0);

    set_cfg(8, 1, 0, 0, 0);
    rx_q.delete();
    wave.delete();
    seg(1'b0, 12 * OSR);
    for (int k = 0; k < wave.size(); k++) begin
      rxd_drv = wave[k];
      @(posedge clk); #1;
    end
    chk("brk_busy_low", 32'(rx_busy), 0);
    chk_rx("brk", 8'h00, 1, 1, 1);
    rxd_drv = 1'b1;
    repeat (200) begin @(posedge clk); #1; end
    chk("brk_single", 32'(rx_q.size()), 1);

    // One-clock glitch in IDLE is a false start
    set_cfg(8, 0, 0, 0, 0);
    rx_q.delete();
    rxd_drv = 1'b0;
    @(posedge clk); #1;
    rxd_drv = 1'b1;
    saw = 0; dropped = 0;
    for (int n = 0; n < OSR / 2 + 3 + 3; n++) begin
      if (rx_busy === 1'b1) saw = 1;
      if (saw && rx_busy === 1'b0) dropped = 1;
      @(posedge clk); #1;
    end
    chk("glitch_busy", {30'd0, saw, dropped}, 3);
    repeat (40) begin @(posedge clk); #1; end
    chk("glitch_noval", 32'(rx_q.size()), 0);

    // Spike inside data bit 5 is outvoted
    rx_q.delete();
    build(8'hF0, 0, 0);
    wave[(1 + 5) * OSR + OSR / 2 - 1] = 1'b0;
    rx_drive(40);
    chk_rx("spike", 8'hF0, 0, 0, 0);

    // Disable mid-DATA drops the frame
    loop = 1'b1;
    rx_q.delete();
    tx_data  = 8'hFF;
    tx_valid = 1'b1;
    accept();
    tx_valid = 1'b0;
    repeat (3 * OSR) begin @(posedge clk); #1; end
    cfg_en = 1'b0;
    @(posedge clk); #1;
    chk("dis_txd", 32'(txd), 1);
    chk("dis_state", {29'd0, tx_ready, tx_busy, rx_busy}, 0);
    repeat (5) begin @(posedge clk); #1; end
    cfg_en = 1'b1;
    repeat (200) begin @(posedge clk); #1; end
    chk("dis_noval", 32'(rx_q.size()), 0);
    build(8'h3C, 0, 0);
    tx_run(8'h3C, 1, mism, busy, tail, rerr);
    chk("reen_wave", 32'(mism), 0);
    chk_rx("reen", 8'h3C, 0, 0, 0);

    // Asynchronous reset mid-frame
    tx_data  = 8'h81;
    tx_valid = 1'b1;
    accept();
    tx_valid = 1'b0;
    repeat (30) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_tx", {29'd0, txd, tx_ready, tx_busy}, 4);
    chk("arst_rx", {20'd0, rx_busy, rx_valid, rx_data,
                    rx_perr, rx_ferr, rx_break}, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (5) @(posedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
